// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-memory fetch/loader arbiter.
package imem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      LOAD    = 2'd2
   } arb_state_e;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 4;
   localparam int ADDR_MAX_W  = 64;

   // Byte address to word address at a generous width; callers truncate to their port width.
   function automatic logic [ADDR_MAX_W-1:0] word_addr(input logic [ADDR_MAX_W-1:0] byte_addr);
      return byte_addr >> 2;
   endfunction

endpackage

// File: rtl/imem_lat_counter.sv
// Loadable down-counter that tracks the remaining read latency; done_o marks
// the completion cycle (count at zero).
module imem_lat_counter
   import imem_arb_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Arbitrates the single-ported instruction memory between fetch reads and loader writes.
// Optional stall-cycle counter is built when IMEM_ARB_PERF_EN is defined.
module imem_fetch_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   input  logic              fetch_flush,
   output logic              fetch_ready,
   output logic              fetch_rvalid,
   output logic [DATA_W-1:0] fetch_rdata,
   output logic              stall_f,
   input  logic              ld_active,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       stall_cycles
);

   localparam int CNT_W = $clog2(MEM_LAT) + 1;

   if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_check
      $error("imem_fetch_arbiter: MEM_LAT outside legal range");
   end

   arb_state_e        state_q, state_d;
   logic              kill_q, kill_d;
   logic              issue, ld_beat, rvalid, ld_rdy, cnt_dec, cnt_done;
   logic [ADDR_W-3:0] fetch_word, ld_word;

   assign fetch_word = (ADDR_W-2)'(word_addr(ADDR_MAX_W'(fetch_addr)));
   assign ld_word    = (ADDR_W-2)'(word_addr(ADDR_MAX_W'(ld_addr)));

   imem_lat_counter #(.W(CNT_W)) u_lat_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (issue),
      .load_val_i (CNT_W'(MEM_LAT - 1)),
      .dec_i      (cnt_dec),
      .done_o     (cnt_done)
   );

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      kill_d  = kill_q;
      issue   = 1'b0;
      ld_beat = 1'b0;
      rvalid  = 1'b0;
      ld_rdy  = 1'b0;
      cnt_dec = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ld_active) begin
               state_d = LOAD;
            end else if (fetch_req) begin
               issue   = 1'b1;
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (cnt_done) begin
               // A flush on the completion cycle drops this response but not a read issued now.
               rvalid = ~kill_q & ~fetch_flush;
               kill_d = 1'b0;
               if (!ld_active && fetch_req) begin
                  issue = 1'b1;
               end else if (ld_active) begin
                  state_d = LOAD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_dec = 1'b1;
               if (fetch_flush) kill_d = 1'b1;
            end
         end
         LOAD: begin
            ld_rdy  = 1'b1;
            ld_beat = ld_valid;
            if (!ld_active && !ld_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
      end
   end

   // Outputs are forced low for the whole time reset is asserted.
   assign fetch_ready  = rst & issue;
   assign fetch_rvalid = rst & rvalid;
   assign fetch_rdata  = fetch_rvalid ? mem_rdata : '0;
   assign stall_f      = rst & fetch_req & ~issue;
   assign ld_ready     = rst & ld_rdy;
   assign mem_en       = rst & (issue | ld_beat);
   assign mem_we       = rst & ld_beat;
   assign mem_addr     = !rst ? '0 : (ld_beat ? ld_word : fetch_word);
   assign mem_wdata    = (rst && ld_beat) ? ld_data : '0;

`ifdef IMEM_ARB_PERF_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else if (stall_f && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench: instance 0 runs MEM_LAT=1, instance 1 runs MEM_LAT=3, each with
// its own behavioural memory initialised to mem[i] = i.
module tb_imem_fetch_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk, rst;
   logic          fetch_req [2], fetch_flush [2], ld_active [2], ld_valid [2];
   logic [AW-1:0] fetch_addr [2], ld_addr [2];
   logic [DW-1:0] ld_data [2];
   logic          fetch_ready [2], fetch_rvalid [2], stall_f [2], ld_ready [2];
   logic          mem_en [2], mem_we [2];
   logic [DW-1:0] fetch_rdata [2], mem_wdata [2], mem_rdata [2];
   logic [AW-3:0] mem_addr [2];
   logic [31:0]   stall_cycles [2];

   int errors, checks;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : 3;

      imem_fetch_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
         .clk          (clk),
         .rst          (rst),
         .fetch_req    (fetch_req[g]),
         .fetch_addr   (fetch_addr[g]),
         .fetch_flush  (fetch_flush[g]),
         .fetch_ready  (fetch_ready[g]),
         .fetch_rvalid (fetch_rvalid[g]),
         .fetch_rdata  (fetch_rdata[g]),
         .stall_f      (stall_f[g]),
         .ld_active    (ld_active[g]),
         .ld_valid     (ld_valid[g]),
         .ld_addr      (ld_addr[g]),
         .ld_data      (ld_data[g]),
         .ld_ready     (ld_ready[g]),
         .mem_en       (mem_en[g]),
         .mem_we       (mem_we[g]),
         .mem_addr     (mem_addr[g]),
         .mem_wdata    (mem_wdata[g]),
         .mem_rdata    (mem_rdata[g]),
         .stall_cycles (stall_cycles[g])
      );

      logic [DW-1:0] mem  [64];
      logic [DW-1:0] pipe [LAT];

      initial for (int i = 0; i < 64; i++) mem[i] = DW'(i);

      always @(posedge clk) begin
         if (mem_en[g] && mem_we[g]) mem[mem_addr[g][5:0]] <= mem_wdata[g];
         pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g][5:0]] : 'x;
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end

      assign mem_rdata[g] = pipe[LAT-1];
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      for (int d = 0; d < 2; d++) begin
         fetch_req[d]   = 1'b0;
         fetch_flush[d] = 1'b0;
         fetch_addr[d]  = '0;
         ld_active[d]   = 1'b0;
         ld_valid[d]    = 1'b0;
         ld_addr[d]     = '0;
         ld_data[d]     = '0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      fetch_req[0] = 1'b1;
      fetch_req[1] = 1'b1;
      ld_active[1] = 1'b1;
      ld_valid[1]  = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++; if (fetch_ready[d] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b, expected 0", d, fetch_ready[d]); end
         checks++; if (stall_f[d] !== 1'b0) begin errors++; $display("FAIL reset_stall[%0d]: got %b, expected 0", d, stall_f[d]); end
         checks++; if (ld_ready[d] !== 1'b0) begin errors++; $display("FAIL reset_ld_ready[%0d]: got %b, expected 0", d, ld_ready[d]); end
         checks++; if (mem_en[d] !== 1'b0) begin errors++; $display("FAIL reset_mem_en[%0d]: got %b, expected 0", d, mem_en[d]); end
         checks++; if (fetch_rvalid[d] !== 1'b0) begin errors++; $display("FAIL reset_rvalid[%0d]: got %b, expected 0", d, fetch_rvalid[d]); end
         checks++; if (stall_cycles[d] !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles[%0d]: got %0d, expected 0", d, stall_cycles[d]); end
      end
      clear_inputs();
      next_cycle();
      rst = 1'b1;
      next_cycle();
   endtask

   // MEM_LAT=1: one read accepted per cycle, responses one cycle later.
   task automatic test_pipelined_fetch();
      logic [DW-1:0] exp_data;
      for (int i = 0; i < 4; i++) begin
         fetch_req[0]  = (i < 3);
         fetch_addr[0] = AW'(i * 4);
         @(negedge clk);
         checks++; if (fetch_ready[0] !== (i < 3)) begin errors++; $display("FAIL pipe_ready[%0d]: got %b, expected %b", i, fetch_ready[0], (i < 3)); end
         checks++; if (stall_f[0] !== 1'b0) begin errors++; $display("FAIL pipe_stall[%0d]: got %b, expected 0", i, stall_f[0]); end
         checks++; if (fetch_rvalid[0] !== (i > 0)) begin errors++; $display("FAIL pipe_rvalid[%0d]: got %b, expected %b", i, fetch_rvalid[0], (i > 0)); end
         if (i > 0) begin
            exp_data = DW'(i - 1);
            checks++; if (fetch_rdata[0] !== exp_data) begin errors++; $display("FAIL pipe_rdata[%0d]: got %h, expected %h", i, fetch_rdata[0], exp_data); end
         end
         next_cycle();
      end
      clear_inputs();
   endtask

   // MEM_LAT=3: single read at 0x10 with fetch_req held while waiting.
   task automatic test_latency();
      logic [4:0] req_v   = 5'b00111;
      logic [4:0] en_v    = 5'b00001;
      logic [4:0] stall_v = 5'b00110;
      logic [4:0] rv_v    = 5'b01000;
      for (int i = 0; i < 5; i++) begin
         fetch_req[1]  = req_v[i];
         fetch_addr[1] = 32'h10;
         @(negedge clk);
         checks++; if (mem_en[1] !== en_v[i]) begin errors++; $display("FAIL lat_mem_en[%0d]: got %b, expected %b", i, mem_en[1], en_v[i]); end
         checks++; if (stall_f[1] !== stall_v[i]) begin errors++; $display("FAIL lat_stall[%0d]: got %b, expected %b", i, stall_f[1], stall_v[i]); end
         checks++; if (fetch_rvalid[1] !== rv_v[i]) begin errors++; $display("FAIL lat_rvalid[%0d]: got %b, expected %b", i, fetch_rvalid[1], rv_v[i]); end
         if (i == 0) begin
            checks++; if (mem_addr[1] !== 30'd4) begin errors++; $display("FAIL lat_mem_addr: got %h, expected 4", mem_addr[1]); end
         end
         if (i == 3) begin
            checks++; if (fetch_rdata[1] !== 32'd4) begin errors++; $display("FAIL lat_rdata: got %h, expected 4", fetch_rdata[1]); end
         end
         next_cycle();
      end
      clear_inputs();
   endtask

   // Scenario 0: flush mid-wait kills 0x20; scenario 1: flush on the completion cycle.
   task automatic test_flush();
      logic [6:0]    req_v = 7'b0001001;
      logic [6:0]    rv_v  = 7'b1000000;
      logic [6:0]    flush_v;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] exp_data;
      for (int s = 0; s < 2; s++) begin
         flush_v  = (s == 0) ? 7'b0000010 : 7'b0001000;
         a0       = (s == 0) ? 32'h20 : 32'h0;
         a1       = (s == 0) ? 32'h40 : 32'h8;
         exp_data = (s == 0) ? 32'd16 : 32'd2;
         for (int i = 0; i < 7; i++) begin
            fetch_req[1]   = req_v[i];
            fetch_flush[1] = flush_v[i];
            fetch_addr[1]  = (i == 0) ? a0 : a1;
            @(negedge clk);
            checks++; if (fetch_rvalid[1] !== rv_v[i]) begin errors++; $display("FAIL flush%0d_rvalid[%0d]: got %b, expected %b", s, i, fetch_rvalid[1], rv_v[i]); end
            checks++; if (fetch_ready[1] !== req_v[i]) begin errors++; $display("FAIL flush%0d_ready[%0d]: got %b, expected %b", s, i, fetch_ready[1], req_v[i]); end
            if (i == 6) begin
               checks++; if (fetch_rdata[1] !== exp_data) begin errors++; $display("FAIL flush%0d_rdata: got %h, expected %h", s, fetch_rdata[1], exp_data); end
            end
            next_cycle();
         end
      end
      clear_inputs();
   endtask

   // Loader raised mid-read: the read drains, two beats are written, readback of 0x4.
   task automatic test_loader_drain();
      fetch_req[1] = 1'b1; fetch_addr[1] = 32'h0;
      @(negedge clk);
      checks++; if (fetch_ready[1] !== 1'b1) begin errors++; $display("FAIL ld_first_issue: got %b, expected 1", fetch_ready[1]); end
      next_cycle();
      fetch_req[1] = 1'b0; ld_active[1] = 1'b1;
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         checks++; if (ld_ready[1] !== 1'b0) begin errors++; $display("FAIL ld_drain_ready[%0d]: got %b, expected 0", i, ld_ready[1]); end
         checks++; if (fetch_rvalid[1] !== (i == 3)) begin errors++; $display("FAIL ld_drain_rvalid[%0d]: got %b, expected %b", i, fetch_rvalid[1], (i == 3)); end
         checks++; if (mem_en[1] !== 1'b0) begin errors++; $display("FAIL ld_drain_mem_en[%0d]: got %b, expected 0", i, mem_en[1]); end
         next_cycle();
      end
      ld_valid[1] = 1'b1; ld_addr[1] = 32'h0; ld_data[1] = 32'hDEADBEEF; fetch_req[1] = 1'b1;
      @(negedge clk);
      checks++; if (ld_ready[1] !== 1'b1) begin errors++; $display("FAIL ld_beat0_ready: got %b, expected 1", ld_ready[1]); end
      checks++; if ({mem_en[1], mem_we[1]} !== 2'b11) begin errors++; $display("FAIL ld_beat0_strobe: got %b, expected 11", {mem_en[1], mem_we[1]}); end
      checks++; if (mem_wdata[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_beat0_wdata: got %h, expected deadbeef", mem_wdata[1]); end
      checks++; if ({stall_f[1], fetch_ready[1]} !== 2'b10) begin errors++; $display("FAIL ld_beat0_stall: got %b, expected 10", {stall_f[1], fetch_ready[1]}); end
      next_cycle();
      ld_active[1] = 1'b0; ld_addr[1] = 32'h4; ld_data[1] = 32'h12345678;
      @(negedge clk);
      checks++; if ({mem_en[1], mem_we[1]} !== 2'b11) begin errors++; $display("FAIL ld_beat1_strobe: got %b, expected 11", {mem_en[1], mem_we[1]}); end
      checks++; if (mem_addr[1] !== 30'd1) begin errors++; $display("FAIL ld_beat1_addr: got %h, expected 1", mem_addr[1]); end
      checks++; if (mem_wdata[1] !== 32'h12345678) begin errors++; $display("FAIL ld_beat1_wdata: got %h, expected 12345678", mem_wdata[1]); end
      next_cycle();
      ld_valid[1] = 1'b0;
      @(negedge clk);
      checks++; if ({mem_en[1], stall_f[1]} !== 2'b01) begin errors++; $display("FAIL ld_exit: got en/stall %b, expected 01", {mem_en[1], stall_f[1]}); end
      next_cycle();
      fetch_addr[1] = 32'h4;
      @(negedge clk);
      checks++; if (fetch_ready[1] !== 1'b1) begin errors++; $display("FAIL ld_readback_issue: got %b, expected 1", fetch_ready[1]); end
      next_cycle();
      fetch_req[1] = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      checks++; if (fetch_rvalid[1] !== 1'b1) begin errors++; $display("FAIL ld_readback_rvalid: got %b, expected 1", fetch_rvalid[1]); end
      checks++; if (fetch_rdata[1] !== 32'h12345678) begin errors++; $display("FAIL ld_readback_rdata: got %h, expected 12345678", fetch_rdata[1]); end
      next_cycle();
      clear_inputs();
   endtask

   // Five stalled fetch cycles while the loader owns the memory.
   task automatic test_perf_counter();
      logic [31:0] exp_cnt;
`ifdef IMEM_ARB_PERF_EN
      exp_cnt = 32'd5;
`else
      exp_cnt = 32'd0;
`endif
      ld_active[0] = 1'b1;
      next_cycle();
      fetch_req[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if ({ld_ready[0], stall_f[0]} !== 2'b11) begin errors++; $display("FAIL perf_load_stall[%0d]: got %b, expected 11", i, {ld_ready[0], stall_f[0]}); end
         next_cycle();
      end
      clear_inputs();
      next_cycle();
      @(negedge clk);
      checks++; if (stall_cycles[0] !== exp_cnt) begin errors++; $display("FAIL perf_count: got %0d, expected %0d", stall_cycles[0], exp_cnt); end
      next_cycle();
   endtask

   // Reset for one cycle during RD_WAIT discards the pending response.
   task automatic test_reset_mid_read();
      fetch_req[1] = 1'b1; fetch_addr[1] = 32'h10;
      @(negedge clk);
      checks++; if (fetch_ready[1] !== 1'b1) begin errors++; $display("FAIL rstmid_issue: got %b, expected 1", fetch_ready[1]); end
      next_cycle();
      rst = 1'b0;
      ld_valid[1] = 1'b1;
      @(negedge clk);
      checks++; if ({fetch_ready[1], stall_f[1], mem_en[1], fetch_rvalid[1], ld_ready[1]} !== 5'b0) begin errors++; $display("FAIL rstmid_outputs: got %b, expected 00000", {fetch_ready[1], stall_f[1], mem_en[1], fetch_rvalid[1], ld_ready[1]}); end
      checks++; if (stall_cycles[0] !== 32'd0) begin errors++; $display("FAIL rstmid_perf_clear: got %0d, expected 0", stall_cycles[0]); end
      next_cycle();
      rst = 1'b1;
      ld_valid[1] = 1'b0;
      fetch_addr[1] = 32'h8;
      @(negedge clk);
      checks++; if (fetch_ready[1] !== 1'b1) begin errors++; $display("FAIL rstmid_reissue: got %b, expected 1", fetch_ready[1]); end
      checks++; if (mem_addr[1] !== 30'd2) begin errors++; $display("FAIL rstmid_reissue_addr: got %h, expected 2", mem_addr[1]); end
      next_cycle();
      fetch_req[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (fetch_rvalid[1] !== (i == 2)) begin errors++; $display("FAIL rstmid_rvalid[%0d]: got %b, expected %b", i, fetch_rvalid[1], (i == 2)); end
         if (i == 2) begin
            checks++; if (fetch_rdata[1] !== 32'd2) begin errors++; $display("FAIL rstmid_rdata: got %h, expected 2", fetch_rdata[1]); end
         end
         next_cycle();
      end
      clear_inputs();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_pipelined_fetch();
      test_latency();
      test_flush();
      test_loader_drain();
      test_perf_counter();
      test_reset_mid_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
